// File: rtl/snake_game_ctrl.sv
// ---------------------------------------------------------------------------
// snake_game_ctrl
//
// Game-flow controller for snake_core. Sequences the game through
// IDLE -> READY (countdown) -> PLAY <-> PAUSE -> OVER, keeps snake_core in
// reset while no game is running, and generates the core's movement step
// pulse plus a one-second play tick. Snake speed rises with score.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset
//   key_val        keypad code, valid while key_pressed is high
//   key_pressed    level, high while a key is held
//   core_game_over game-over flag from snake_core
//   score          current score from snake_core (0..99)
//   state          phase: IDLE=0 READY=1 PLAY=2 PAUSE=3 OVER=4
//   core_rst_n     active-low reset to snake_core (low in IDLE/READY)
//   step_tick      one-cycle pulse, core advances one cell
//   sec_tick       one-cycle pulse per elapsed play second
//   ready_cnt      seconds left in READY, 0 elsewhere
//   speed_level    current speed level 0..3
//   high_score     best score since power-on / last reset
//
// Key interface: there is no handshake. key_pressed is a level; a key event
// is its rising edge (current sample 1, registered sample 0), and key_val is
// taken in that same cycle. Holding a key never produces a second event.
// ---------------------------------------------------------------------------
module snake_game_ctrl #(
    parameter int          ONE_SEC    = 50000000,
    parameter int          STEP_BASE  = 25000000,
    parameter int          STEP_DEC   = 5000000,
    parameter int          READY_SECS = 3,
    parameter logic [3:0]  START_KEY  = 4'h5,
    parameter logic [3:0]  PAUSE_KEY  = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_val,
    input  logic       key_pressed,
    input  logic       core_game_over,
    input  logic [6:0] score,
    output logic [2:0] state,
    output logic       core_rst_n,
    output logic       step_tick,
    output logic       sec_tick,
    output logic [2:0] ready_cnt,
    output logic [1:0] speed_level,
    output logic [6:0] high_score
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [25:0] SEC_LAST   = 26'(ONE_SEC - 1);
    localparam logic [24:0] STEP_BASE_W = 25'(STEP_BASE);
    localparam logic [24:0] STEP_DEC_W  = 25'(STEP_DEC);
    localparam logic [2:0]  READY_INIT = 3'(READY_SECS);

    state_e      state_q, state_d;
    logic        key_prev_q, key_prev_d;
    logic [2:0]  ready_cnt_q, ready_cnt_d;
    logic [24:0] step_cnt_q, step_cnt_d;
    logic [25:0] sec_cnt_q, sec_cnt_d;
    logic        step_tick_q, step_tick_d;
    logic        sec_tick_q, sec_tick_d;
    logic [1:0]  speed_level_q, speed_level_d;
    logic [6:0]  high_score_q, high_score_d;
    // High for the first cycle spent in OVER; the high score is captured then.
    logic        over_first_q, over_first_d;

    logic        key_event;
    logic        start_ev;
    logic        pause_ev;
    logic [24:0] step_last;
    logic [1:0]  speed_target;
    logic        sec_wrap;
    logic        step_wrap;

    assign key_event = key_pressed & ~key_prev_q;
    assign start_ev  = key_event & (key_val == START_KEY);
    assign pause_ev  = key_event & (key_val == PAUSE_KEY);

    // Step period shrinks by STEP_DEC per level; counter wraps at period-1.
    assign step_last = STEP_BASE_W - (25'(speed_level_q) * STEP_DEC_W) - 25'd1;
    assign step_wrap = (step_cnt_q == step_last);
    assign sec_wrap  = (sec_cnt_q == SEC_LAST);

    // Target level is score/8, saturated at 3.
    assign speed_target = (score[6:3] > 4'd3) ? 2'd3 : score[4:3];

    always_comb begin
        state_d       = state_q;
        key_prev_d    = key_pressed;
        ready_cnt_d   = ready_cnt_q;
        step_cnt_d    = step_cnt_q;
        sec_cnt_d     = sec_cnt_q;
        step_tick_d   = 1'b0;
        sec_tick_d    = 1'b0;
        speed_level_d = speed_level_q;
        high_score_d  = high_score_q;
        over_first_d  = 1'b0;

        if (state_q == ST_OVER && over_first_q && score > high_score_q) begin
            high_score_d = score;
        end

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_ev) begin
                    state_d       = ST_READY;
                    ready_cnt_d   = READY_INIT;
                    sec_cnt_d     = 26'd0;
                    speed_level_d = 2'd0;
                end
            end
            ST_READY: begin
                if (sec_wrap) begin
                    sec_cnt_d   = 26'd0;
                    ready_cnt_d = ready_cnt_q - 3'd1;
                    if (ready_cnt_q == 3'd1) begin
                        state_d    = ST_PLAY;
                        step_cnt_d = 25'd0;
                    end
                end else begin
                    sec_cnt_d = sec_cnt_q + 26'd1;
                end
            end
            ST_PLAY: begin
                if (core_game_over) begin
                    state_d      = ST_OVER;
                    over_first_d = 1'b1;
                end else if (pause_ev) begin
                    // Counters hold from this cycle on, so no tick can be
                    // registered into a cycle that is no longer PLAY.
                    state_d = ST_PAUSE;
                end else begin
                    if (step_wrap) begin
                        step_cnt_d    = 25'd0;
                        step_tick_d   = 1'b1;
                        // New level governs the period that starts now.
                        speed_level_d = speed_target;
                    end else begin
                        step_cnt_d = step_cnt_q + 25'd1;
                    end
                    if (sec_wrap) begin
                        sec_cnt_d  = 26'd0;
                        sec_tick_d = 1'b1;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 26'd1;
                    end
                end
            end
            ST_PAUSE: begin
                if (pause_ev) begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            key_prev_q    <= 1'b0;
            ready_cnt_q   <= 3'd0;
            step_cnt_q    <= 25'd0;
            sec_cnt_q     <= 26'd0;
            step_tick_q   <= 1'b0;
            sec_tick_q    <= 1'b0;
            speed_level_q <= 2'd0;
            high_score_q  <= 7'd0;
            over_first_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_prev_q    <= key_prev_d;
            ready_cnt_q   <= ready_cnt_d;
            step_cnt_q    <= step_cnt_d;
            sec_cnt_q     <= sec_cnt_d;
            step_tick_q   <= step_tick_d;
            sec_tick_q    <= sec_tick_d;
            speed_level_q <= speed_level_d;
            high_score_q  <= high_score_d;
            over_first_q  <= over_first_d;
        end
    end

    assign state       = state_q;
    assign core_rst_n  = (state_q == ST_PLAY) || (state_q == ST_PAUSE) || (state_q == ST_OVER);
    assign step_tick   = step_tick_q;
    assign sec_tick    = sec_tick_q;
    assign ready_cnt   = ready_cnt_q;
    assign speed_level = speed_level_q;
    assign high_score  = high_score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snake_game_ctrl
//
// Bench for snake_game_ctrl with small timing parameters. A behavioural
// model (countdown-based timers) predicts every cycle's outputs; the
// prediction is queued when the inputs are applied and a monitor on the
// falling edge pops and compares. A few directed checks pin the key
// scenarios to absolute constants.
// ---------------------------------------------------------------------------
module tb_snake_game_ctrl;

    localparam int          ONE_SEC    = 10;
    localparam int          STEP_BASE  = 8;
    localparam int          STEP_DEC   = 2;
    localparam int          READY_SECS = 2;
    localparam logic [3:0]  START_KEY  = 4'h5;
    localparam logic [3:0]  PAUSE_KEY  = 4'h0;

    localparam int M_IDLE  = 0;
    localparam int M_READY = 1;
    localparam int M_PLAY  = 2;
    localparam int M_PAUSE = 3;
    localparam int M_OVER  = 4;

    // ---------------- clock / reset / DUT ----------------
    logic       clk;
    logic       rst_n;
    logic [3:0] key_val;
    logic       key_pressed;
    logic       core_game_over;
    logic [6:0] score;
    logic [2:0] state;
    logic       core_rst_n;
    logic       step_tick;
    logic       sec_tick;
    logic [2:0] ready_cnt;
    logic [1:0] speed_level;
    logic [6:0] high_score;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    snake_game_ctrl #(
        .ONE_SEC   (ONE_SEC),
        .STEP_BASE (STEP_BASE),
        .STEP_DEC  (STEP_DEC),
        .READY_SECS(READY_SECS),
        .START_KEY (START_KEY),
        .PAUSE_KEY (PAUSE_KEY)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_val       (key_val),
        .key_pressed   (key_pressed),
        .core_game_over(core_game_over),
        .score         (score),
        .state         (state),
        .core_rst_n    (core_rst_n),
        .step_tick     (step_tick),
        .sec_tick      (sec_tick),
        .ready_cnt     (ready_cnt),
        .speed_level   (speed_level),
        .high_score    (high_score)
    );

    // ---------------- scoreboard ----------------
    logic [17:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Timers are modelled as "cycles left until the event" rather than
    // up-counters; READY is one total countdown from which the displayed
    // seconds are derived by rounding up.
    int m_state, m_ready_left, m_step_left, m_sec_left, m_speed, m_high;
    bit m_prev_key, m_over_entry, m_step_t, m_sec_t;

    function automatic int period(input int lvl);
        return STEP_BASE - lvl * STEP_DEC;
    endfunction

    function automatic int target_level(input int sc);
        return (sc / 8 > 3) ? 3 : sc / 8;
    endfunction

    task automatic model_enter_ready();
        m_state      = M_READY;
        m_ready_left = READY_SECS * ONE_SEC;
        m_speed      = 0;
    endtask

    task automatic model_step(input bit rn, input bit kp, input logic [3:0] kv,
                              input bit go, input int sc);
        bit ev, start, pause;
        m_step_t = 0;
        m_sec_t  = 0;
        if (!rn) begin
            m_state = M_IDLE; m_ready_left = 0; m_step_left = 0; m_sec_left = 0;
            m_speed = 0; m_high = 0; m_prev_key = 0; m_over_entry = 0;
            return;
        end
        ev    = kp && !m_prev_key;
        start = ev && (kv == START_KEY);
        pause = ev && (kv == PAUSE_KEY);
        m_prev_key = kp;
        if (m_state == M_OVER && m_over_entry && sc > m_high) m_high = sc;
        m_over_entry = 0;
        case (m_state)
            M_IDLE, M_OVER: if (start) model_enter_ready();
            M_READY: begin
                m_ready_left--;
                if (m_ready_left == 0) begin
                    m_state     = M_PLAY;
                    m_step_left = period(m_speed);
                    m_sec_left  = ONE_SEC;
                end
            end
            M_PLAY: begin
                if (go) begin
                    m_state      = M_OVER;
                    m_over_entry = 1;
                end else if (pause) begin
                    m_state = M_PAUSE;
                end else begin
                    m_step_left--;
                    if (m_step_left == 0) begin
                        m_step_t    = 1;
                        m_speed     = target_level(sc);
                        m_step_left = period(m_speed);
                    end
                    m_sec_left--;
                    if (m_sec_left == 0) begin
                        m_sec_t    = 1;
                        m_sec_left = ONE_SEC;
                    end
                end
            end
            M_PAUSE: if (pause) m_state = M_PLAY;
            default: m_state = M_IDLE;
        endcase
    endtask

    function automatic logic [17:0] model_outputs();
        logic [2:0] rc;
        logic       crst;
        rc   = (m_state == M_READY) ? 3'((m_ready_left + ONE_SEC - 1) / ONE_SEC) : 3'd0;
        crst = (m_state == M_PLAY) || (m_state == M_PAUSE) || (m_state == M_OVER);
        return {3'(m_state), crst, m_step_t, m_sec_t, rc, 2'(m_speed), 7'(m_high)};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [17:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, core_rst_n, step_tick, sec_tick, ready_cnt, speed_level, high_score};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs at %0t: got st=%0d crst=%0b step=%0b sec=%0b rdy=%0d spd=%0d hi=%0d, expected st=%0d crst=%0b step=%0b sec=%0b rdy=%0d spd=%0d hi=%0d",
                         $time, a[17:15], a[14], a[13], a[12], a[11:9], a[8:7], a[6:0],
                         e[17:15], e[14], e[13], e[12], e[11:9], e[8:7], e[6:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Predict the outcome of the current inputs, then let the edge happen.
    // On return we sit 1 time unit after the edge with outputs settled.
    task automatic tick_cycle();
        model_step(rst_n, key_pressed, key_val, core_game_over, int'(score));
        exp_q.push_back(model_outputs());
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick_cycle();
    endtask

    task automatic press(input logic [3:0] k, input int hold);
        key_val     = k;
        key_pressed = 1'b1;
        repeat (hold) tick_cycle();
        key_pressed = 1'b0;
        key_val     = 4'($urandom_range(0, 15));
        tick_cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int g;
        int r;
        rst_n = 1'b0; key_val = 4'h0; key_pressed = 1'b0;
        core_game_over = 1'b0; score = 7'd0;
        #1;
        run(3);
        check("reset_state", int'(state), M_IDLE);
        check("reset_core_rst_n", int'(core_rst_n), 0);
        check("reset_high_score", int'(high_score), 0);
        rst_n = 1'b1;
        run($urandom_range(1, 4));

        // Held START: one event only, full countdown, then play timing.
        key_val     = START_KEY;
        key_pressed = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick_cycle();
            if (i == 0)  begin check("ready_entry_state", int'(state), M_READY);
                               check("ready_entry_cnt", int'(ready_cnt), 2); end
            if (i == 10) check("ready_cnt_after_1s", int'(ready_cnt), 1);
            if (i == 19) check("ready_last_cycle", int'(state), M_READY);
            if (i == 20) begin check("play_entry_state", int'(state), M_PLAY);
                               check("play_entry_core_rst_n", int'(core_rst_n), 1); end
            if (i == 27) check("no_step_before_p", int'(step_tick), 0);
            if (i == 28) check("first_step_tick", int'(step_tick), 1);
            if (i == 36) check("second_step_tick", int'(step_tick), 1);
            if (i == 49) check("held_start_no_retrigger", int'(state), M_PLAY);
        end
        key_pressed = 1'b0;
        tick_cycle();

        // Pause at step count 5; counts resume from the frozen values.
        g = 0;
        while (g < 40 && !(m_state == M_PLAY && period(m_speed) - m_step_left == 5)) begin
            tick_cycle();
            g++;
        end
        check("reach_step_count_5", g < 40 ? 1 : 0, 1);
        press(PAUSE_KEY, 1);
        check("paused_state", int'(state), M_PAUSE);
        repeat ($urandom_range(4, 12)) begin
            key_val        = 4'($urandom_range(1, 15));
            key_pressed    = 1'($urandom_range(0, 1));
            core_game_over = 1'($urandom_range(0, 1));
            tick_cycle();
        end
        key_pressed = 1'b0; core_game_over = 1'b0;
        tick_cycle();
        press(PAUSE_KEY, 1);
        tick_cycle();
        tick_cycle();
        check("step_3_after_resume", int'(step_tick), 1);

        // Speed scaling with score.
        score = 7'd8;  run(20); check("speed_at_8", int'(speed_level), 1);
        score = 7'd24; run(20); check("speed_at_24", int'(speed_level), 3);
        score = 7'd40; run(10); check("speed_at_40", int'(speed_level), 3);

        // Game over and PAUSE in the same cycle: game over wins.
        score = 7'd17;
        run(3);
        key_val = PAUSE_KEY; key_pressed = 1'b1; core_game_over = 1'b1;
        tick_cycle();
        check("over_beats_pause", int'(state), M_OVER);
        key_pressed = 1'b0; core_game_over = 1'b0;
        tick_cycle();
        check("high_score_17", int'(high_score), 17);
        run(10);

        // Second game ends lower: high score kept.
        press(START_KEY, 1);
        run(20);
        score = 7'd9;
        run(10);
        core_game_over = 1'b1; tick_cycle();
        core_game_over = 1'b0; tick_cycle();
        check("over_second_game", int'(state), M_OVER);
        check("high_score_kept", int'(high_score), 17);

        // Reset during PAUSE clears everything, including the high score.
        press(START_KEY, 1);
        run(25);
        press(PAUSE_KEY, 1);
        run(3);
        check("pause_before_reset", int'(state), M_PAUSE);
        rst_n = 1'b0; tick_cycle(); rst_n = 1'b1;
        check("midgame_reset_state", int'(state), M_IDLE);
        check("midgame_reset_core_rst_n", int'(core_rst_n), 0);
        check("midgame_reset_high_score", int'(high_score), 0);
        run(10);

        // Random traffic checked against the model.
        for (int i = 0; i < 1500; i++) begin
            if (key_pressed) begin
                if ($urandom_range(0, 2) == 0) key_pressed = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 3);
                key_val = (r < 2) ? START_KEY : (r == 2) ? PAUSE_KEY : 4'($urandom_range(0, 15));
                key_pressed = 1'b1;
            end
            core_game_over = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) score = 7'($urandom_range(0, 99));
            rst_n = ($urandom_range(0, 299) != 0);
            tick_cycle();
        end
        rst_n = 1'b1; key_pressed = 1'b0; core_game_over = 1'b0;

        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game-flow controller that sequences `snake_core` through attract, get-ready, play, pause and game-over phases. It holds the core in reset while no game is running. During play it generates the core's movement step pulse and a 1-second tick, and scales snake speed with score. It tracks a session high score for the display path and sits between the keypad decoder and `snake_core`.

## Interface
Parameters:
- `ONE_SEC`, default 50000000: clock cycles per second tick.
- `STEP_BASE`, default 25000000: step period in cycles at speed level 0.
- `STEP_DEC`, default 5000000: cycles removed from the step period per speed level.
- `READY_SECS`, default 3: get-ready countdown length in seconds (1..7).
- `START_KEY`, default 4'h5: key code that starts or restarts a game.
- `PAUSE_KEY`, default 4'h0: key code that toggles pause.

Ports:
- `clk`  in  1  single system clock, 50 MHz.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `key_val`  in  4  keypad code; valid while `key_pressed` is high.
- `key_pressed`  in  1  level, high while a key is held.
- `core_game_over`  in  1  game-over flag from `snake_core`.
- `score`  in  7  score from `snake_core` (0..99).
- `state`  out  3  phase: IDLE=0, READY=1, PLAY=2, PAUSE=3, OVER=4.
- `core_rst_n`  out  1  reset to `snake_core`; low in IDLE and READY, high in PLAY, PAUSE and OVER.
- `step_tick`  out  1  one-cycle pulse; the core advances one cell per pulse.
- `sec_tick`  out  1  one-cycle pulse per elapsed play second.
- `ready_cnt`  out  3  seconds remaining in READY; 0 outside READY.
- `speed_level`  out  2  current speed level, 0..3.
- `high_score`  out  7  best score this power-on session.

## Operation
- Key events:
  - `key_pressed` is registered once.
  - A key event is the cycle where `key_pressed` is 1 and its registered copy is 0.
  - `key_val` is sampled in that cycle.
  - Held keys produce no repeat events.
- IDLE:
  - START event: go to READY, set `ready_cnt=READY_SECS`, clear the second counter.
  - All other keys are ignored.
- READY:
  - The second counter runs.
  - Each wrap at `ONE_SEC-1` decrements `ready_cnt`.
  - The wrap that takes `ready_cnt` from 1 to 0 enters PLAY, with the step and second counters cleared.
  - Keys are ignored.
- PLAY:
  - The step counter counts 0..P-1 and pulses `step_tick` at P-1, where P = `STEP_BASE - speed_level*STEP_DEC`.
  - The second counter counts 0..`ONE_SEC-1` and pulses `sec_tick` at the wrap.
  - `core_game_over`=1: go to OVER. This has priority over a same-cycle PAUSE event.
  - PAUSE event: go to PAUSE.
- PAUSE:
  - Both counters freeze at their current values; no ticks are generated.
  - PAUSE event: return to PLAY, resuming from the frozen counts.
  - `core_game_over` and all other keys are ignored.
- OVER:
  - No ticks are generated; `core_rst_n` stays high so the final board remains displayed.
  - On the entry cycle, if `score > high_score`, then `high_score <= score`.
  - START event: go to READY with the same initialisation as from IDLE.
- Speed level:
  - Target level = `score[6:3]` saturated to 3.
  - `speed_level` updates only on `step_tick` cycles, so a new period takes effect from the next step.
  - `speed_level` is cleared on entry to READY.
- Widths:
  - Step counter is 25 bits; second counter is 26 bits.
  - Period arithmetic is unsigned. Parameters must satisfy `STEP_BASE > 3*STEP_DEC`; this is not checked in RTL.
- Reset (synchronous, `rst_n`=0 at a clock edge):
  - `state=IDLE`, `core_rst_n=0`, `step_tick=0`, `sec_tick=0`, `ready_cnt=0`, `speed_level=0`, `high_score=0`.
  - All counters and the key edge register are cleared.
  - Reset applied mid-game also clears `high_score`.

## Timing
- `core_rst_n` is decoded from the state register and changes in the same cycle `state` changes.
- Entering PLAY raises `core_rst_n`. The first `step_tick` follows P cycles later; the first `sec_tick` follows `ONE_SEC` cycles later.
- `step_tick` and `sec_tick` are registered: they are high for exactly one cycle, and only while `state`=PLAY.
- READY lasts exactly `READY_SECS*ONE_SEC` cycles.
- A key event changes `state` on the clock edge after the press is sampled: one cycle of latency.
- `core_game_over` to OVER: one cycle. `high_score` is valid the cycle after OVER is entered.

## Test plan
Bench parameters: `ONE_SEC=10`, `STEP_BASE=8`, `STEP_DEC=2`, `READY_SECS=2`.
- Reset, then a START event -> `state` 0→1, `ready_cnt`=2, then 1 after 10 cycles; `state`=2 after 20 cycles with `core_rst_n`=1; first `step_tick` 8 cycles later, then every 8 cycles.
- In PLAY, drive `score` 0→8→24→40 -> `speed_level` becomes 1, 3, 3 on the next `step_tick`; tick spacing becomes 6, then 2.
- In PLAY, a PAUSE event at step count 5 -> no ticks while paused; after a second PAUSE event, the next `step_tick` arrives exactly 3 cycles after resume.
- `core_game_over`=1 and a PAUSE event in the same PLAY cycle -> `state`=4, no further ticks; with `score`=17, `high_score`=17. A later game ending at `score`=9 leaves `high_score`=17.
- `key_pressed` held high for 50 cycles with `START_KEY` in IDLE -> exactly one transition to READY; no re-trigger after READY ends.
- `rst_n` low for one cycle during PAUSE with `high_score`=17 -> `state`=0, `core_rst_n`=0, `high_score`=0, no ticks.
